// File: rtl/pipeline_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | pipeline_ctrl_pkg: shared types and constants for pipeline control    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH2  = 2'd1,
    MC_WAIT = 2'd2
  } hz_state_t;

  localparam int                    REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO   = 5'd0;
  localparam logic [31:0]           NOP_INSTR  = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// +----------------------------------------------------------------------+
// | sat_counter: W-bit up counter that sticks at all-ones                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
// +----------------------------------------------------------------------+
// | pipeline_hazard_controller: stall/flush sequencing for 5-stage pipe  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_redirect,
  input  logic                  ex_mc_start,
  input  logic                  mc_done,
  output logic                  pc_write_enable,
  output logic                  if_id_write_enable,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  id_ex_write_enable,
  output logic                  ex_mem_bubble,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  hz_state_t r_state;
  hz_state_t w_next_state;
  logic      w_lu;
  logic      w_flush_inc;
  logic      w_stall_inc;

  assign w_lu = ex_is_load && (ex_rd != REG_ZERO) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                 (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state       = r_state;
    pc_write_enable    = 1'b1;
    if_id_write_enable = 1'b1;
    if_id_flush        = 1'b0;
    id_ex_bubble       = 1'b0;
    id_ex_write_enable = 1'b1;
    ex_mem_bubble      = 1'b0;
    w_flush_inc        = 1'b0;

    if (!reset_n) begin
      // Reset overrides whatever state the sequencer was in.
      w_next_state       = RUN;
      pc_write_enable    = 1'b0;
      if_id_write_enable = 1'b0;
      id_ex_write_enable = 1'b0;
      if_id_flush        = 1'b1;
      id_ex_bubble       = 1'b1;
      ex_mem_bubble      = 1'b1;
    end else begin
      unique case (r_state)
        RUN: begin
          if (ex_redirect) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            w_flush_inc  = 1'b1;
            w_next_state = FLUSH2;
          end else if (ex_mc_start) begin
            // A same-cycle completion means the op never needed to stall.
            if (!mc_done) begin
              pc_write_enable    = 1'b0;
              if_id_write_enable = 1'b0;
              id_ex_write_enable = 1'b0;
              ex_mem_bubble      = 1'b1;
              w_next_state       = MC_WAIT;
            end
          end else if (w_lu) begin
            pc_write_enable    = 1'b0;
            if_id_write_enable = 1'b0;
            id_ex_bubble       = 1'b1;
          end
        end
        FLUSH2: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          w_next_state = RUN;
        end
        MC_WAIT: begin
          if (mc_done) begin
            w_next_state = RUN;
          end else begin
            pc_write_enable    = 1'b0;
            if_id_write_enable = 1'b0;
            id_ex_write_enable = 1'b0;
            ex_mem_bubble      = 1'b1;
          end
        end
        default: begin
          w_next_state = RUN;
        end
      endcase
    end
  end

  assign w_stall_inc = reset_n && !pc_write_enable;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (w_stall_inc),
    .count   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (w_flush_inc),
    .count   (flush_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
// +----------------------------------------------------------------------+
// | tb_pipeline_hazard_controller: directed vector bench                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pipeline_hazard_controller;

  localparam int CNT_W = 4;

  // Control bundle: {pc_we, if_id_we, if_id_flush, id_ex_bubble, id_ex_we, ex_mem_bubble}
  localparam logic [5:0] O_RUN   = 6'b110010;
  localparam logic [5:0] O_LU    = 6'b000110;
  localparam logic [5:0] O_FLUSH = 6'b111110;
  localparam logic [5:0] O_MC    = 6'b000001;
  localparam logic [5:0] O_RST   = 6'b001101;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_uses_rs1, id_uses_rs2, ex_is_load;
  logic             ex_redirect, ex_mc_start, mc_done;
  logic             pc_write_enable, if_id_write_enable, if_id_flush;
  logic             id_ex_bubble, id_ex_write_enable, ex_mem_bubble;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [5:0]       ctl;

  int total = 0;
  int bad   = 0;
  int exp_stalls;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, ld, mcs, mcd;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  assign ctl = {pc_write_enable, if_id_write_enable, if_id_flush,
                id_ex_bubble, id_ex_write_enable, ex_mem_bubble};

  pipeline_hazard_controller #(.CNT_W(CNT_W)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .id_rs1             (id_rs1),
    .id_rs2             (id_rs2),
    .id_uses_rs1        (id_uses_rs1),
    .id_uses_rs2        (id_uses_rs2),
    .ex_rd              (ex_rd),
    .ex_is_load         (ex_is_load),
    .ex_redirect        (ex_redirect),
    .ex_mc_start        (ex_mc_start),
    .mc_done            (mc_done),
    .pc_write_enable    (pc_write_enable),
    .if_id_write_enable (if_id_write_enable),
    .if_id_flush        (if_id_flush),
    .id_ex_bubble       (id_ex_bubble),
    .id_ex_write_enable (id_ex_write_enable),
    .ex_mem_bubble      (ex_mem_bubble),
    .stall_cycles       (stall_cycles),
    .flush_count        (flush_count)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_is_load = 1'b0;
    ex_redirect = 1'b0; ex_mc_start = 1'b0; mc_done = 1'b0;
  endtask

  task automatic set_lu();
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic next_cycle();
    @(negedge clk);
    idle();
  endtask

  initial begin
    vecs[0] = '{rs1:5'd0, rs2:5'd0, rd:5'd0, u1:0, u2:0, ld:0, mcs:0, mcd:0, exp:O_RUN};
    vecs[1] = '{rs1:5'd0, rs2:5'd5, rd:5'd5, u1:0, u2:1, ld:1, mcs:0, mcd:0, exp:O_LU};
    vecs[2] = '{rs1:5'd0, rs2:5'd0, rd:5'd0, u1:0, u2:1, ld:1, mcs:0, mcd:0, exp:O_RUN};
    vecs[3] = '{rs1:5'd7, rs2:5'd3, rd:5'd7, u1:1, u2:1, ld:1, mcs:0, mcd:0, exp:O_LU};
    vecs[4] = '{rs1:5'd7, rs2:5'd3, rd:5'd7, u1:1, u2:1, ld:0, mcs:0, mcd:0, exp:O_RUN};
    vecs[5] = '{rs1:5'd7, rs2:5'd7, rd:5'd7, u1:0, u2:0, ld:1, mcs:0, mcd:0, exp:O_RUN};
    vecs[6] = '{rs1:5'd0, rs2:5'd0, rd:5'd0, u1:0, u2:0, ld:0, mcs:1, mcd:1, exp:O_RUN};
    vecs[7] = '{rs1:5'd0, rs2:5'd0, rd:5'd0, u1:0, u2:0, ld:0, mcs:0, mcd:1, exp:O_RUN};

    idle();
    reset_n = 1'b0;
    @(negedge clk); #1;
    chk("reset_ctl", 32'(ctl), 32'(O_RST));
    @(negedge clk); #1;
    chk("reset_stall_cnt", 32'(stall_cycles), 32'd0);
    chk("reset_flush_cnt", 32'(flush_count), 32'd0);

    next_cycle();
    reset_n = 1'b1;
    #1 chk("run_default", 32'(ctl), 32'(O_RUN));

    exp_stalls = 0;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; ex_rd = vecs[i].rd;
      id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
      ex_is_load = vecs[i].ld; ex_mc_start = vecs[i].mcs; mc_done = vecs[i].mcd;
      #1 chk($sformatf("vec%0d", i), 32'(ctl), 32'(vecs[i].exp));
      if (!vecs[i].exp[5]) exp_stalls++;
    end
    next_cycle();
    #1 chk("vec_stall_cnt", 32'(stall_cycles), 32'(exp_stalls));
    chk("vec_ctl_after", 32'(ctl), 32'(O_RUN));

    // Redirect together with a load-use hazard: flush wins, two flushed slots.
    next_cycle();
    ex_redirect = 1'b1; set_lu();
    #1 chk("redir_cycle", 32'(ctl), 32'(O_FLUSH));
    next_cycle();
    set_lu(); ex_mc_start = 1'b1;
    #1 chk("flush2_cycle", 32'(ctl), 32'(O_FLUSH));
    next_cycle();
    #1 chk("post_flush", 32'(ctl), 32'(O_RUN));
    chk("flush_cnt", 32'(flush_count), 32'd1);
    chk("stall_after_redir", 32'(stall_cycles), 32'(exp_stalls));

    // Multi-cycle op: launch, 3 waits, done on the 5th cycle.
    next_cycle();
    ex_mc_start = 1'b1;
    #1 chk("mc_launch", 32'(ctl), 32'(O_MC));
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      #1 chk($sformatf("mc_wait%0d", i), 32'(ctl), 32'(O_MC));
    end
    next_cycle();
    mc_done = 1'b1;
    #1 chk("mc_done", 32'(ctl), 32'(O_RUN));
    next_cycle();
    #1 chk("mc_after", 32'(ctl), 32'(O_RUN));
    chk("mc_stall_cnt", 32'(stall_cycles), 32'(exp_stalls + 4));

    // Reset in the 2nd MC_WAIT cycle.
    next_cycle();
    ex_mc_start = 1'b1;
    next_cycle();
    #1 chk("mc2_wait1", 32'(ctl), 32'(O_MC));
    next_cycle();
    reset_n = 1'b0;
    #1 chk("mid_reset_ctl", 32'(ctl), 32'(O_RST));
    next_cycle();
    reset_n = 1'b1;
    #1 chk("post_reset_ctl", 32'(ctl), 32'(O_RUN));
    chk("post_reset_stall", 32'(stall_cycles), 32'd0);
    chk("post_reset_flush", 32'(flush_count), 32'd0);

    // Saturation: 20 back-to-back load-use stalls on a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      set_lu();
      if (i == 14) begin
        #1 chk("sat_lu_ctl", 32'(ctl), 32'(O_LU));
        chk("sat_pre", 32'(stall_cycles), 32'd14);
      end
    end
    next_cycle();
    #1 chk("sat_value", 32'(stall_cycles), 32'd15);
    next_cycle();
    #1 chk("sat_held", 32'(stall_cycles), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
